// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot scan encoder family: scan state
// encoding and the index-width helper.
package onehot_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Index width for a vector of the given width (WIDTH >= 2 gives >= 1 bit).
  function automatic int code_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/onehot_scan_encoder_prio_index.sv
// Combinational priority encoder: returns the index of the lowest (or highest)
// set bit of a vector together with an any-set flag; index is 0 when empty.
module prio_index
  import onehot_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = code_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    idx,
  output logic             any_set
);

  // Walk away from the winning end so the preferred bit is written last.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (vec[i]) idx = CW'(i);
      end else begin
        if (vec[WIDTH-1-i]) idx = CW'(WIDTH - 1 - i);
      end
    end
  end

  assign any_set = |vec;

endmodule

// File: rtl/onehot_scan_encoder.sv
// Sequential encoder: accepts a request vector and emits the index of each set
// bit, one per beat, marking the final beat and flagging all-zero vectors.
module onehot_scan_encoder
  import onehot_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = code_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_code,
  output logic             out_last,
  output logic             out_none
);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;

  logic [CW-1:0]    sel_idx;
  logic             sel_any;
  logic [WIDTH-1:0] sel_mask;
  logic             single_left;
  logic             accept;
  logic             xfer;

  prio_index #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec     (pending_q),
    .idx     (sel_idx),
    .any_set (sel_any)
  );

  assign sel_mask    = WIDTH'(1) << sel_idx;
  assign single_left = (pending_q & (pending_q - WIDTH'(1))) == '0;

  assign out_valid = (state_q == SCAN);
  assign out_code  = out_valid ? sel_idx : '0;
  assign out_last  = out_valid && single_left;
  assign out_none  = out_valid && zero_q;

  assign xfer     = out_valid && out_ready;
  assign in_ready = (state_q == IDLE) || (xfer && out_last);
  assign accept   = in_valid && in_ready;

  // A new accept on the final transfer overrides the return to IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    if (xfer) begin
      if (sel_any) pending_d = pending_q & ~sel_mask;
      if (out_last) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
    if (accept) begin
      state_d   = SCAN;
      pending_d = in_data;
      zero_d    = (in_data == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Parametrised, sequential successor to the team's fixed 8-to-3 encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake and emits the binary index of every set bit, one index per beat, in priority order.
- Marks the last index of each vector and flags all-zero vectors explicitly; no X is ever driven.
- Sits between interrupt/request collectors and downstream index-consuming logic (decoders, mux selects, dispatch queues).

Parameters:
- WIDTH, 8, width of the input vector (legal: >= 2).
- MSB_FIRST, 0, scan order: 0 = lowest set bit first, 1 = highest set bit first.
- CW (localparam), $clog2(WIDTH), width of the index output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  WIDTH  request vector.
- out_valid  output  1  out_code / out_last / out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_code  output  CW  index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  accepted vector was all zeros; only valid with out_valid.

Behaviour:
- Reset: asserting rst_n low, asynchronously or mid-scan, forces:
  - state = IDLE, pending register = 0, out_valid = 0, out_code = 0, out_last = 0, out_none = 0.
  - Any partially emitted vector is discarded.
  - in_ready = 1 from the first cycle after deassertion.
- States:
  - IDLE: no vector held.
  - SCAN: pending register holds the not-yet-emitted bits of the current vector, plus a zero-flag.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready, which is permitted.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - pending <= in_data; zero-flag <= (in_data == 0); state <= SCAN.
- Latency: out_valid rises in the cycle after accept (1 cycle).
- Back-to-back vectors: run with zero bubble cycles.
- In SCAN:
  - out_valid = 1.
  - out_code = index of lowest set bit of pending (MSB_FIRST=0) or highest set bit (MSB_FIRST=1).
  - out_last = pending has at most one bit set.
  - out_none = zero-flag.
- Zero vector: produces exactly one beat with out_code = 0, out_last = 1, out_none = 1.
- Output handshake: a beat transfers when out_valid && out_ready.
  - On transfer: the emitted bit is cleared from pending.
  - If out_last and no new accept: state <= IDLE and out_valid falls next cycle.
  - If out_last with a simultaneous accept: pending is loaded with the new vector and state stays SCAN.
- Backpressure: while out_valid && !out_ready, out_code, out_last and out_none stay stable and pending is unchanged.
- in_data is ignored when in_ready = 0. in_ready = 0 in SCAN except on the last transfer.
- Outside SCAN: out_code, out_last and out_none are driven 0.
- A vector of N set bits takes exactly max(N, 1) transfers. Every index 0..WIDTH-1 must be reachable, including WIDTH-1 when WIDTH is not a power of two.
- Datapath: pending is the only multi-bit register. Priority select is combinational from pending; there is no registered output stage.

Decomposition:
- Shared package onehot_pkg: scan-state enum (IDLE, SCAN) and a CW-width helper function.
- One natural sub-module: prio_index (parameters WIDTH, MSB_FIRST).
  - Purely combinational: vector -> CW-bit index plus any-set flag.
  - Instantiated once on the pending register; reused elsewhere for single-cycle encoding.
- Top level holds the FSM, pending register, and bit-clear/last logic.

Test Plan:
- Reset, then in_data=8'b0000_0100 with out_ready=1 -> one beat one cycle later: out_code=2, out_last=1, out_none=0; then out_valid=0.
- MSB_FIRST=0, in_data=8'b1001_0010, out_ready=1 -> out_code 1, 4, 7 on consecutive cycles; out_last only on 7. Repeat with MSB_FIRST=1 -> 7, 4, 1.
- in_data=8'h00 -> single beat out_code=0, out_last=1, out_none=1.
- Backpressure: 8'b0110_0000 with out_ready low 3 cycles -> out_code holds 5, in_ready=0, in_valid ignored; release -> 5 then 6 (last).
- Back-to-back: 8'h01 then 8'h80 offered continuously -> in_ready high on the last transfer, codes 0, 7 on consecutive cycles with no bubble.
- WIDTH=12, in_data=12'h801, rst_n pulsed low after the first beat (code 0) -> outputs 0 immediately, code 11 never emitted, in_ready=1 after release.
